// File: rtl/imm_gen_if.sv
// Decode-side handshake bundle for the immediate generator.
// The master drives instructions and accepts results; the slave is the generator.
interface imm_gen_if #(
  parameter int INSTR_W = 16,
  parameter int IMM_W   = 16
);
  logic               in_valid;
  logic               in_ready;
  logic [INSTR_W-1:0] instruction;
  logic [2:0]         imm_src;
  logic               out_valid;
  logic               out_ready;
  logic [IMM_W-1:0]   imm_out;
  logic               imm_prefixed;
  logic               fmt_err;
  logic               prefix_err;

  modport master (
    output in_valid, instruction, imm_src, out_ready,
    input  in_ready, out_valid, imm_out, imm_prefixed, fmt_err, prefix_err
  );

  modport slave (
    input  in_valid, instruction, imm_src, out_ready,
    output in_ready, out_valid, imm_out, imm_prefixed, fmt_err, prefix_err
  );
endinterface

// File: rtl/imm_gen_pipe.sv
// Pipelined immediate generator: decodes one of five immediate formats, optionally
// prepends the payload of a preceding prefix instruction, and registers the result once.
module imm_gen_pipe #(
  parameter int         INSTR_W    = 16,
  parameter int         IMM_W      = 16,
  parameter int         PREFIX_W   = 12,
  parameter logic [3:0] PREFIX_OPC = 4'hF
) (
  input logic      clk,
  input logic      rst_n,
  input logic      flush,
  imm_gen_if.slave bus
);

  localparam int EXT_W = IMM_W + PREFIX_W + 8;

  typedef enum logic {IDLE, PREFIXED} state_t;

  state_t              state_q, state_d;
  logic [PREFIX_W-1:0] prefix_q;
  logic                vld_p1;
  logic [IMM_W-1:0]    imm_p1;
  logic                pfx_p1;
  logic                fmt_p1;
  logic                perr_p1;

  logic                in_ready;
  logic                xfer;
  logic                is_pfx;
  logic                pending;
  logic [EXT_W-1:0]    field;
  logic [EXT_W-1:0]    vcat;
  int                  fw;
  int                  vw;
  logic                sgn;
  logic                legal;
  logic                shl;
  logic [IMM_W-1:0]    imm_d;

  // Sign-extends from bit w-1 of v when sgn is set; v is already zero above bit w-1.
  function automatic logic [IMM_W-1:0] extend(input logic [EXT_W-1:0] v, input int w,
                                              input logic sgn_i);
    logic signed [EXT_W-1:0] t;
    t = $signed(v << (EXT_W - w));
    if (sgn_i) t = t >>> (EXT_W - w);
    else       t = $signed(v);
    return t[IMM_W-1:0];
  endfunction

  assign in_ready = !flush && (!vld_p1 || bus.out_ready);
  assign xfer     = bus.in_valid && in_ready;
  assign is_pfx   = (bus.instruction[15:12] == PREFIX_OPC);
  assign pending  = (state_q == PREFIXED);

  always_comb begin
    field = '0;
    fw    = 8;
    sgn   = 1'b1;
    legal = 1'b1;
    shl   = 1'b0;
    case (bus.imm_src)
      3'b000: field[7:0] = bus.instruction[8:1];
      3'b001: begin field[5:0] = bus.instruction[5:0]; fw = 6; end
      3'b010: begin field[4:0] = bus.instruction[5:1]; fw = 5; sgn = 1'b0; end
      3'b011: begin field[7:0] = bus.instruction[8:1]; sgn = 1'b0; end
      3'b100: begin field[7:0] = bus.instruction[8:1]; shl = 1'b1; end
      default: legal = 1'b0;
    endcase
    vcat = field;
    vw   = fw;
    if (pending) begin
      vcat = field | (EXT_W'(prefix_q) << fw);
      vw   = fw + PREFIX_W;
    end
    imm_d = extend(vcat, vw, sgn);
    if (shl)    imm_d = imm_d << 1;
    if (!legal) imm_d = '0;
  end

  always_comb begin
    state_d = state_q;
    if (flush)      state_d = IDLE;
    else if (xfer)  state_d = is_pfx ? PREFIXED : IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      prefix_q <= '0;
    end else begin
      state_q <= state_d;
      if (flush)              prefix_q <= '0;
      else if (xfer && is_pfx) prefix_q <= bus.instruction[PREFIX_W-1:0];
    end
  end

  // Stage p1: registered result beat
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1  <= 1'b0;
      imm_p1  <= '0;
      pfx_p1  <= 1'b0;
      fmt_p1  <= 1'b0;
      perr_p1 <= 1'b0;
    end else if (flush) begin
      vld_p1  <= 1'b0;
      perr_p1 <= 1'b0;
    end else begin
      perr_p1 <= xfer && is_pfx && pending;
      if (xfer && !is_pfx) begin
        vld_p1 <= 1'b1;
        imm_p1 <= imm_d;
        pfx_p1 <= pending;
        fmt_p1 <= !legal;
      end else if (bus.out_ready) begin
        vld_p1 <= 1'b0;
      end
    end
  end

  assign bus.in_ready     = in_ready;
  assign bus.out_valid    = vld_p1;
  assign bus.imm_out      = imm_p1;
  assign bus.imm_prefixed = pfx_p1;
  assign bus.fmt_err      = fmt_p1;
  assign bus.prefix_err   = perr_p1;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Bench for imm_gen_pipe: directed scenarios plus randomized traffic against an
// arithmetic reference model of the immediate formats and prefix rules.
module tb_imm_gen_pipe;

  logic clk;
  logic rst_n;
  logic flush;
  int   passed;
  int   total;

  imm_gen_if #(.INSTR_W(16), .IMM_W(16)) bus ();

  imm_gen_pipe #(.INSTR_W(16), .IMM_W(16), .PREFIX_W(12), .PREFIX_OPC(4'hF)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: field value, optional prefix prepended, sign handled by integer arithmetic.
  function automatic logic [15:0] model_imm(input logic [15:0] instr, input logic [2:0] src,
                                            input bit pfx, input logic [11:0] pv);
    int     fw, lo, w;
    bit     sg;
    longint f, v;
    case (src)
      3'd0: begin fw = 8; lo = 1; sg = 1; end
      3'd1: begin fw = 6; lo = 0; sg = 1; end
      3'd2: begin fw = 5; lo = 1; sg = 0; end
      3'd3: begin fw = 8; lo = 1; sg = 0; end
      3'd4: begin fw = 8; lo = 1; sg = 1; end
      default: return 16'h0000;
    endcase
    f = (longint'(instr) >> lo) % (longint'(1) << fw);
    v = pfx ? (longint'(pv) * (longint'(1) << fw) + f) : f;
    w = fw + (pfx ? 12 : 0);
    if (sg && v >= (longint'(1) << (w - 1))) v = v - (longint'(1) << w);
    if (src == 3'd4) v = v * 2;
    return v[15:0];
  endfunction

  task automatic step(input logic v, input logic [15:0] instr, input logic [2:0] src,
                      input logic ordy, input logic fl);
    @(negedge clk);
    bus.in_valid    = v;
    bus.instruction = instr;
    bus.imm_src     = src;
    bus.out_ready   = ordy;
    flush           = fl;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    @(negedge clk);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    flush         = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    flush = 1'b0;
    bus.in_valid = 1'b0; bus.instruction = '0; bus.imm_src = '0; bus.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if ({bus.out_valid, bus.imm_out, bus.imm_prefixed, bus.fmt_err, bus.prefix_err} !== 20'h0) begin
      $display("FAIL reset_outputs: got ov=%b imm=%h pf=%b fe=%b pe=%b, want all zero",
               bus.out_valid, bus.imm_out, bus.imm_prefixed, bus.fmt_err, bus.prefix_err);
    end else passed++;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    total++;
    if (bus.in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b want 1", bus.in_ready);
    else passed++;
  endtask

  task automatic test_formats();
    step(1'b1, 16'h01FE, 3'd0, 1'b1, 1'b0);
    total++;
    if (bus.out_valid !== 1'b1 || bus.imm_out !== 16'hFFFF || bus.imm_prefixed !== 1'b0)
      $display("FAIL s8: got ov=%b imm=%h pf=%b want 1 FFFF 0", bus.out_valid, bus.imm_out, bus.imm_prefixed);
    else passed++;
    step(1'b1, 16'h01FE, 3'd4, 1'b1, 1'b0);
    total++;
    if (bus.imm_out !== 16'hFFFE) $display("FAIL b8: got %h want FFFE", bus.imm_out);
    else passed++;
    step(1'b1, 16'h0020, 3'd1, 1'b1, 1'b0);
    total++;
    if (bus.imm_out !== 16'hFFE0) $display("FAIL s6: got %h want FFE0", bus.imm_out);
    else passed++;
    step(1'b1, 16'h003E, 3'd2, 1'b1, 1'b0);
    total++;
    if (bus.imm_out !== 16'h001F) $display("FAIL u5: got %h want 001F", bus.imm_out);
    else passed++;
    step(1'b1, 16'h01FE, 3'd3, 1'b1, 1'b0);
    total++;
    if (bus.imm_out !== 16'h00FF) $display("FAIL u8: got %h want 00FF", bus.imm_out);
    else passed++;
    step(1'b1, 16'h01FE, 3'd6, 1'b1, 1'b0);
    total++;
    if (bus.out_valid !== 1'b1 || bus.imm_out !== 16'h0000 || bus.fmt_err !== 1'b1)
      $display("FAIL illegal_fmt: got ov=%b imm=%h fe=%b want 1 0000 1", bus.out_valid, bus.imm_out, bus.fmt_err);
    else passed++;
    idle_inputs();
  endtask

  task automatic test_prefix();
    step(1'b1, 16'hF00A, 3'd0, 1'b1, 1'b0);
    total++;
    if (bus.out_valid !== 1'b0) $display("FAIL prefix_no_beat: got ov=%b want 0", bus.out_valid);
    else passed++;
    step(1'b1, 16'h003E, 3'd2, 1'b1, 1'b0);
    total++;
    if (bus.out_valid !== 1'b1 || bus.imm_out !== 16'h015F || bus.imm_prefixed !== 1'b1)
      $display("FAIL prefix_u5: got ov=%b imm=%h pf=%b want 1 015F 1", bus.out_valid, bus.imm_out, bus.imm_prefixed);
    else passed++;
    step(1'b1, 16'hF001, 3'd0, 1'b1, 1'b0);
    step(1'b1, 16'hF002, 3'd0, 1'b1, 1'b0);
    total++;
    if (bus.prefix_err !== 1'b1) $display("FAIL double_prefix_err: got %b want 1", bus.prefix_err);
    else passed++;
    step(1'b1, 16'h0002, 3'd0, 1'b1, 1'b0);
    total++;
    if (bus.imm_out !== 16'h0201 || bus.prefix_err !== 1'b0 || bus.imm_prefixed !== 1'b1)
      $display("FAIL double_prefix_imm: got imm=%h pe=%b pf=%b want 0201 0 1", bus.imm_out, bus.prefix_err, bus.imm_prefixed);
    else passed++;
    idle_inputs();
  endtask

  task automatic test_backpressure();
    int bad;
    bad = 0;
    step(1'b1, 16'h01FE, 3'd3, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 16'h0020, 3'd1, 1'b0, 1'b0);
      if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1 || bus.imm_out !== 16'h00FF) bad++;
    end
    total++;
    if (bad != 0) $display("FAIL backpressure_hold: got %0d bad cycles want 0 (last imm=%h rdy=%b)", bad, bus.imm_out, bus.in_ready);
    else passed++;
    @(negedge clk);
    bus.out_ready = 1'b1;
    #1;
    total++;
    if (bus.in_ready !== 1'b1) $display("FAIL backpressure_release: got in_ready=%b want 1", bus.in_ready);
    else passed++;
    @(posedge clk);
    #1;
    total++;
    if (bus.imm_out !== 16'hFFE0 || bus.out_valid !== 1'b1)
      $display("FAIL backpressure_next: got ov=%b imm=%h want 1 FFE0", bus.out_valid, bus.imm_out);
    else passed++;
    idle_inputs();
  endtask

  task automatic test_flush_reset();
    step(1'b1, 16'hF00A, 3'd0, 1'b1, 1'b0);
    step(1'b1, 16'hF123, 3'd0, 1'b1, 1'b1);
    total++;
    if (bus.out_valid !== 1'b0 || bus.prefix_err !== 1'b0)
      $display("FAIL flush_clear: got ov=%b pe=%b want 0 0", bus.out_valid, bus.prefix_err);
    else passed++;
    step(1'b1, 16'h01FE, 3'd0, 1'b1, 1'b0);
    total++;
    if (bus.imm_out !== 16'hFFFF || bus.imm_prefixed !== 1'b0)
      $display("FAIL flush_then_s8: got imm=%h pf=%b want FFFF 0", bus.imm_out, bus.imm_prefixed);
    else passed++;
    @(negedge clk);
    bus.in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    total++;
    if (bus.out_valid !== 1'b0 || bus.imm_out !== 16'h0000)
      $display("FAIL async_reset: got ov=%b imm=%h want 0 0000", bus.out_valid, bus.imm_out);
    else passed++;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_random();
    bit          m_vld, m_pend, m_pf, m_fe, m_pe, xfer, isp, rdy;
    logic [15:0] m_imm;
    logic [11:0] m_pv;
    int          bad_rdy, bad_out;
    logic        v, o, fl;
    logic [15:0] ins;
    logic [2:0]  src;
    m_vld = 0; m_pend = 0; m_pf = 0; m_fe = 0; m_pe = 0; m_imm = '0; m_pv = '0;
    bad_rdy = 0; bad_out = 0;
    for (int c = 0; c < 400; c++) begin
      v   = ($urandom_range(0, 3) != 0);
      o   = ($urandom_range(0, 3) != 0);
      fl  = ($urandom_range(0, 19) == 0);
      ins = 16'($urandom);
      if ($urandom_range(0, 3) == 0) ins[15:12] = 4'hF;
      src = 3'($urandom_range(0, 7));
      @(negedge clk);
      bus.in_valid = v; bus.instruction = ins; bus.imm_src = src; bus.out_ready = o; flush = fl;
      rdy = !fl && (!m_vld || o);
      #1;
      if (bus.in_ready !== rdy) bad_rdy++;
      @(posedge clk);
      isp  = (ins[15:12] == 4'hF);
      xfer = v && rdy;
      if (fl) begin
        m_vld = 0; m_pend = 0; m_pv = '0; m_pe = 0;
      end else begin
        m_pe = xfer && isp && m_pend;
        if (xfer && isp) begin
          m_pend = 1; m_pv = ins[11:0];
          if (o) m_vld = 0;
        end else if (xfer) begin
          m_imm = model_imm(ins, src, m_pend, m_pv);
          m_pf  = m_pend;
          m_fe  = (src > 3'd4);
          m_vld = 1; m_pend = 0;
        end else if (o) m_vld = 0;
      end
      #1;
      if (bus.out_valid !== m_vld || bus.prefix_err !== m_pe) bad_out++;
      else if (m_vld && (bus.imm_out !== m_imm || bus.imm_prefixed !== m_pf || bus.fmt_err !== m_fe)) begin
        bad_out++;
        if (bad_out < 5)
          $display("FAIL random_beat: cycle %0d got imm=%h pf=%b fe=%b want %h %b %b",
                   c, bus.imm_out, bus.imm_prefixed, bus.fmt_err, m_imm, m_pf, m_fe);
      end
    end
    total++;
    if (bad_rdy != 0) $display("FAIL random_in_ready: got %0d wrong cycles want 0", bad_rdy);
    else passed++;
    total++;
    if (bad_out != 0) $display("FAIL random_outputs: got %0d wrong cycles want 0", bad_out);
    else passed++;
    idle_inputs();
  endtask

  initial begin
    passed = 0;
    total  = 0;
    test_reset();
    test_formats();
    test_prefix();
    test_backpressure();
    test_flush_reset();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
